// File: rtl/cpu_pkg.sv
// Shared CPU front-end types and constants.
package cpu_pkg;

  localparam int unsigned ADDR_W      = 64;
  localparam int unsigned INSTR_W     = 32;
  localparam int unsigned INSTR_BYTES = 4;

  localparam logic [INSTR_W-1:0] BUBBLE_INSTR = 32'h0000_0000;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    HOLD  = 2'd1,
    DRAIN = 2'd2
  } fetch_state_t;

endpackage : cpu_pkg

// File: rtl/pc_register.sv
// Program counter: 64-bit register with load enable and async reset to RESET_PC.
module pc_register
  import cpu_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              load_en_i,
  input  logic [ADDR_W-1:0] pc_i,
  output logic [ADDR_W-1:0] pc_o
);

  logic [ADDR_W-1:0] pc_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pc_q <= RESET_PC;
    end else if (load_en_i) begin
      pc_q <= pc_i;
    end
  end

  assign pc_o = pc_q;

endmodule : pc_register

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC sequencing, memory request handshake, skid buffer and IF/ID register.
module fetch_stage
  import cpu_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               reset_n,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_data,
  input  logic               stall,
  input  logic               redirect,
  input  logic [ADDR_W-1:0]  redirect_pc,
  output logic [INSTR_W-1:0] if_id_instr,
  output logic [ADDR_W-1:0]  if_id_pc,
  output logic               if_id_valid
);

  fetch_state_t state_q, state_d;

  logic               req_q, req_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic               ifid_valid_q, ifid_valid_d;
  logic [INSTR_W-1:0] ifid_instr_q, ifid_instr_d;
  logic [ADDR_W-1:0]  ifid_pc_q, ifid_pc_d;
  logic [INSTR_W-1:0] skid_instr_q, skid_instr_d;
  logic [ADDR_W-1:0]  skid_pc_q, skid_pc_d;

  logic               pc_load_c;
  logic [ADDR_W-1:0]  pc_d;
  logic [ADDR_W-1:0]  pc_cur;
  logic               xfer_c;
  logic [ADDR_W-1:0]  redirect_tgt_c;
  logic [ADDR_W-1:0]  pc_inc_c;

  pc_register #(
    .RESET_PC (RESET_PC)
  ) u_pc (
    .clk       (clk),
    .reset_n   (reset_n),
    .load_en_i (pc_load_c),
    .pc_i      (pc_d),
    .pc_o      (pc_cur)
  );

  // A late ack while no request is outstanding (e.g. just after reset) is ignored.
  assign xfer_c         = req_q & imem_ack;
  assign redirect_tgt_c = redirect_pc & ~(ADDR_W'(INSTR_BYTES) - ADDR_W'(1));
  assign pc_inc_c       = pc_cur + ADDR_W'(INSTR_BYTES);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= FETCH;
      req_q        <= 1'b0;
      addr_q       <= RESET_PC;
      ifid_valid_q <= 1'b0;
      ifid_instr_q <= BUBBLE_INSTR;
      ifid_pc_q    <= '0;
      skid_instr_q <= BUBBLE_INSTR;
      skid_pc_q    <= '0;
    end else begin
      state_q      <= state_d;
      req_q        <= req_d;
      addr_q       <= addr_d;
      ifid_valid_q <= ifid_valid_d;
      ifid_instr_q <= ifid_instr_d;
      ifid_pc_q    <= ifid_pc_d;
      skid_instr_q <= skid_instr_d;
      skid_pc_q    <= skid_pc_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    pc_load_c    = 1'b0;
    pc_d         = pc_cur;
    ifid_valid_d = ifid_valid_q;
    ifid_instr_d = ifid_instr_q;
    ifid_pc_d    = ifid_pc_q;
    skid_instr_d = skid_instr_q;
    skid_pc_d    = skid_pc_q;

    if (redirect) begin
      // Flush wins over stall and ack in every state; an unanswered request must drain first.
      pc_load_c    = 1'b1;
      pc_d         = redirect_tgt_c;
      ifid_valid_d = 1'b0;
      ifid_instr_d = BUBBLE_INSTR;
      skid_instr_d = BUBBLE_INSTR;
      skid_pc_d    = '0;
      state_d      = (req_q && !imem_ack) ? DRAIN : FETCH;
    end else begin
      case (state_q)
        FETCH: begin
          if (xfer_c) begin
            pc_load_c = 1'b1;
            pc_d      = pc_inc_c;
            if (stall) begin
              skid_instr_d = imem_data;
              skid_pc_d    = pc_cur;
              state_d      = HOLD;
            end else begin
              ifid_valid_d = 1'b1;
              ifid_instr_d = imem_data;
              ifid_pc_d    = pc_cur;
            end
          end else if (!stall) begin
            ifid_valid_d = 1'b0;
            ifid_instr_d = BUBBLE_INSTR;
          end
        end
        HOLD: begin
          if (!stall) begin
            ifid_valid_d = 1'b1;
            ifid_instr_d = skid_instr_q;
            ifid_pc_d    = skid_pc_q;
            state_d      = FETCH;
          end
        end
        DRAIN: begin
          if (imem_ack) begin
            state_d = FETCH;
          end
        end
        default: begin
          state_d = FETCH;
        end
      endcase
    end

    // Request/address are registered from the next state so they change only on clk.
    req_d  = (state_d != HOLD);
    addr_d = (state_d == DRAIN) ? addr_q : pc_d;
  end

  assign imem_req    = req_q;
  assign imem_addr   = addr_q;
  assign if_id_valid = ifid_valid_q;
  assign if_id_instr = ifid_instr_q;
  assign if_id_pc    = ifid_pc_q;

endmodule : fetch_stage

// File: tb/tb_fetch_stage.sv
// Directed and randomized checks of fetch_stage against a transaction-level reference model.
module tb_fetch_stage;
  import cpu_pkg::*;

  localparam logic [63:0] RST_PC = 64'h0;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        imem_req;
  logic [63:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_data = 32'h0;
  logic        stall = 1'b0;
  logic        redirect = 1'b0;
  logic [63:0] redirect_pc = 64'h0;
  logic [31:0] if_id_instr;
  logic [63:0] if_id_pc;
  logic        if_id_valid;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: what the fetch unit is doing, not how it is encoded.
  logic        m_req;
  logic [63:0] m_addr;
  logic [63:0] m_pc;
  logic        m_parked;
  logic [31:0] m_park_instr;
  logic [63:0] m_park_pc;
  logic        m_drain;
  logic        m_v;
  logic [31:0] m_instr;
  logic [63:0] m_ifpc;

  fetch_stage #(.RESET_PC(RST_PC)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_data   (imem_data),
    .stall       (stall),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .if_id_instr (if_id_instr),
    .if_id_pc    (if_id_pc),
    .if_id_valid (if_id_valid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_req = 1'b0; m_addr = RST_PC; m_pc = RST_PC;
    m_parked = 1'b0; m_park_instr = 32'h0; m_park_pc = 64'h0;
    m_drain = 1'b0; m_v = 1'b0; m_instr = BUBBLE_INSTR; m_ifpc = 64'h0;
  endtask

  task automatic compare_model(input string tag);
    chk({tag, ".req"},   64'(imem_req),    64'(m_req));
    chk({tag, ".addr"},  imem_addr,        m_addr);
    chk({tag, ".valid"}, 64'(if_id_valid), 64'(m_v));
    chk({tag, ".instr"}, 64'(if_id_instr), 64'(m_instr));
    if (m_v) chk({tag, ".pc"}, if_id_pc, m_ifpc);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, ".req"},   64'(imem_req),    64'h0);
    chk({tag, ".addr"},  imem_addr,        RST_PC);
    chk({tag, ".valid"}, 64'(if_id_valid), 64'h0);
    chk({tag, ".instr"}, 64'(if_id_instr), 64'(BUBBLE_INSTR));
    chk({tag, ".pc"},    if_id_pc,         64'h0);
  endtask

  // Drive one cycle of inputs (called away from the clock edge), advance the model, check after the edge.
  task automatic cycle(input logic ack, input logic [31:0] data, input logic stl,
                       input logic rd, input logic [63:0] rpc, input string tag);
    logic xfer;
    logic drain_n;
    imem_ack = ack; imem_data = data; stall = stl; redirect = rd; redirect_pc = rpc;
    xfer = m_req && ack;
    drain_n = 1'b0;
    if (rd) begin
      drain_n  = m_req && !ack;
      m_pc     = {rpc[63:2], 2'b00};
      m_parked = 1'b0;
      m_v      = 1'b0;
      m_instr  = BUBBLE_INSTR;
    end else if (m_drain) begin
      drain_n = !ack;
    end else if (m_parked) begin
      if (!stl) begin
        m_v = 1'b1; m_instr = m_park_instr; m_ifpc = m_park_pc; m_parked = 1'b0;
      end
    end else if (xfer) begin
      if (stl) begin
        m_park_instr = data; m_park_pc = m_pc; m_parked = 1'b1;
      end else begin
        m_v = 1'b1; m_instr = data; m_ifpc = m_pc;
      end
      m_pc = m_pc + 64'd4;
    end else if (!stl) begin
      m_v = 1'b0; m_instr = BUBBLE_INSTR;
    end
    m_drain = drain_n;
    m_req   = !m_parked;
    if (!m_drain) m_addr = m_pc;
    @(posedge clk);
    #1;
    compare_model(tag);
  endtask

  initial begin
    logic        ack;
    logic        stl;
    logic        rd;
    logic [63:0] rpc;

    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    reset_n = 1'b1;

    // First edge after release: request at RESET_PC.
    cycle(1'b0, 32'h0, 1'b0, 1'b0, 64'h0, "first_req");
    chk("first_req.lit_req",  64'(imem_req), 64'h1);
    chk("first_req.lit_addr", imem_addr,     64'h0);

    // Streaming, one instruction per cycle.
    cycle(1'b1, 32'hA, 1'b0, 1'b0, 64'h0, "stream_a");
    chk("stream_a.lit", {if_id_pc[31:0], if_id_instr}, {32'h0, 32'hA});
    cycle(1'b1, 32'hB, 1'b0, 1'b0, 64'h0, "stream_b");
    chk("stream_b.lit", {if_id_pc[31:0], if_id_instr}, {32'h4, 32'hB});
    cycle(1'b1, 32'hC, 1'b0, 1'b0, 64'h0, "stream_c");
    chk("stream_c.lit", {if_id_pc[31:0], if_id_instr}, {32'h8, 32'hC});
    chk("stream_c.valid", 64'(if_id_valid), 64'h1);

    // Redirect back to 4, then park the instruction at PC 8 under stall.
    cycle(1'b1, 32'hDEAD, 1'b0, 1'b1, 64'h4, "redir_4");
    cycle(1'b1, 32'hB, 1'b0, 1'b0, 64'h0, "refetch_b");
    cycle(1'b1, 32'hC, 1'b1, 1'b0, 64'h0, "stall_ack");
    chk("stall_ack.lit_req", 64'(imem_req), 64'h0);
    cycle(1'b0, 32'h0, 1'b1, 1'b0, 64'h0, "stall_hold1");
    cycle(1'b0, 32'h0, 1'b1, 1'b0, 64'h0, "stall_hold2");
    chk("stall_hold2.lit_ifid", {if_id_pc[31:0], if_id_instr}, {32'h4, 32'hB});
    cycle(1'b0, 32'h0, 1'b0, 1'b0, 64'h0, "unstall");
    chk("unstall.lit_ifid", {if_id_pc[31:0], if_id_instr}, {32'h8, 32'hC});
    chk("unstall.lit_addr", imem_addr, 64'd12);

    // Redirect while request to 16 is outstanding; ack arrives two cycles later.
    cycle(1'b1, 32'hD, 1'b0, 1'b0, 64'h0, "fetch_12");
    cycle(1'b0, 32'h0, 1'b0, 1'b1, 64'h103, "drain_redir");
    chk("drain_redir.lit_addr", imem_addr, 64'd16);
    cycle(1'b0, 32'h0, 1'b0, 1'b0, 64'h0, "drain_wait");
    cycle(1'b1, 32'hBAD0, 1'b0, 1'b0, 64'h0, "drain_ack");
    chk("drain_ack.lit_valid", 64'(if_id_valid), 64'h0);
    chk("drain_ack.lit_addr",  imem_addr,        64'h100);

    // Redirect, stall and ack together: flush wins.
    cycle(1'b1, 32'hE, 1'b1, 1'b1, 64'h200, "flush_wins");
    chk("flush_wins.lit_valid", 64'(if_id_valid), 64'h0);
    chk("flush_wins.lit_addr",  imem_addr,        64'h200);
    chk("flush_wins.lit_req",   64'(imem_req),    64'h1);

    // PC wrap at the top of the address space; low target bits ignored.
    cycle(1'b1, 32'h0, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, "to_top");
    chk("to_top.lit_addr", imem_addr, 64'hFFFF_FFFF_FFFF_FFFC);
    cycle(1'b1, 32'hF, 1'b0, 1'b0, 64'h0, "wrap");
    chk("wrap.lit_addr", imem_addr, 64'h0);

    // Asynchronous reset in the middle of HOLD, then a stale ack after release.
    cycle(1'b1, 32'h6, 1'b1, 1'b0, 64'h0, "hold_enter");
    cycle(1'b0, 32'h0, 1'b1, 1'b0, 64'h0, "hold_stay");
    #2;
    reset_n = 1'b0;
    #1;
    check_reset_outputs("async_rst");
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("rst_held");
    reset_n = 1'b1;
    cycle(1'b1, 32'hBAD1, 1'b0, 1'b0, 64'h0, "late_ack");
    chk("late_ack.lit_addr", imem_addr, RST_PC);
    cycle(1'b1, 32'h11, 1'b0, 1'b0, 64'h0, "restart");
    chk("restart.lit", {if_id_pc[31:0], if_id_instr}, {32'h0, 32'h11});

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      if (m_req) ack = ($urandom % 3) != 0;
      else       ack = ($urandom % 16) == 0;
      stl = ($urandom % 4) == 0;
      rd  = ($urandom % 12) == 0;
      if (($urandom % 6) == 0) rpc = 64'hFFFF_FFFF_FFFF_FFF0 | 64'($urandom % 16);
      else                     rpc = {32'($urandom), 32'($urandom)};
      cycle(ack, m_addr[31:0] ^ 32'h9E37_79B9, stl, rd, rpc, "rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_fetch_stage

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 SHALL have parameter RESET_PC, default 64'h0, byte address of the first instruction fetched after reset.
REQ-002 SHALL have ports, clock and reset first: clk in 1 clock; reset_n in 1 reset; imem_req out 1 fetch request; imem_addr out 64 fetch byte address; imem_ack in 1 fetch data valid; imem_data in 32 fetched instruction; stall in 1 hold IF/ID (hazard unit); redirect in 1 taken branch/flush; redirect_pc in 64 branch target; if_id_instr out 32 instruction to decode/sign extender; if_id_pc out 64 PC of if_id_instr; if_id_valid out 1 if_id_instr is real.
REQ-003 SHALL use one clock, clk (all state on its rising edge), and reset_n, asynchronous, active-low.

Function
REQ-004 SHALL implement states FETCH (request outstanding), HOLD (instruction parked in skid buffer, downstream stalled), DRAIN (redirected while request outstanding; returning data discarded).
REQ-005 SHALL drive imem_req=1 in FETCH and DRAIN, 0 in HOLD; imem_addr=PC in FETCH, latched old address in DRAIN.
REQ-006 SHALL hold imem_addr stable while imem_req=1 until imem_ack; transfer completes on the cycle imem_req=1 and imem_ack=1; zero-wait-state ack (ack in first request cycle) allowed.
REQ-007 FETCH, ack, stall=0, redirect=0: IF/ID <= {imem_data, PC, valid=1}; PC <= PC+4; stay FETCH (one instruction per cycle sustained).
REQ-008 FETCH, ack, stall=1, redirect=0: skid <= {imem_data, PC}; PC <= PC+4; IF/ID unchanged; go HOLD.
REQ-009 FETCH, no ack, stall=0: if_id_valid <= 0, if_id_instr <= BUBBLE_INSTR (bubble); stall=1: IF/ID unchanged.
REQ-010 HOLD, stall=0, redirect=0: IF/ID <= {skid, valid=1}; go FETCH; HOLD, stall=1: all unchanged.
REQ-011 redirect=1 SHALL take priority over stall and ack in every state: PC <= {redirect_pc[63:2], 2'b00}; if_id_valid <= 0; skid discarded.
REQ-012 redirect in FETCH with ack same cycle, or in HOLD: data discarded; next state FETCH at new PC.
REQ-013 redirect in FETCH without ack: next state DRAIN; DRAIN ends on ack (data discarded) -> FETCH at redirected PC; a further redirect in DRAIN overwrites the target PC only.
REQ-014 PC arithmetic SHALL be 64-bit unsigned, wrapping modulo 2^64 (64'hFFFF_FFFF_FFFF_FFFC + 4 = 0).
REQ-015 redirect_pc[1:0] SHALL be ignored (forced 0); no misalignment fault raised.
REQ-016 if_id_instr SHALL be BUBBLE_INSTR whenever if_id_valid=0 so decode and sign extension see a defined word.

Reset
REQ-017 While reset_n=0: state=FETCH, PC=RESET_PC, imem_req=0, imem_addr=RESET_PC, if_id_valid=0, if_id_instr=BUBBLE_INSTR, if_id_pc=0, skid cleared.
REQ-018 First rising clk after reset_n rises: imem_req=1, imem_addr=RESET_PC.
REQ-019 Reset asserted mid-transfer SHALL abandon it; a late imem_ack after reset release SHALL NOT be mistaken for the new request (memory side also reset by reset_n).

Structure
REQ-020 Shared package cpu_pkg SHALL hold fetch_state_t enum (FETCH, HOLD, DRAIN), BUBBLE_INSTR = 32'h0000_0000, INSTR_BYTES = 4.
REQ-021 PC SHALL be a sub-module pc_register: 64-bit, load-enable, async active-low reset to RESET_PC.
REQ-022 Next-PC selection, IF/ID and skid registers and FSM SHALL reside in fetch_stage.

Verification
REQ-023 Reset release, RESET_PC=0, ack every cycle, words 32'hA, 32'hB, 32'hC -> if_id_pc 0, 4, 8 on consecutive cycles, valid=1, instructions A, B, C.
REQ-024 Ack with stall=1 for 3 cycles at PC 8 -> HOLD, imem_req=0, IF/ID unchanged; stall drops -> instr from PC 8 in IF/ID next cycle, next fetch address 12, no loss or duplication.
REQ-025 Redirect to 64'h103 while request to 16 outstanding, ack 2 cycles later -> data discarded, if_id_valid=0, next imem_addr=64'h100.
REQ-026 redirect=1, stall=1, ack=1 same cycle -> flush wins: if_id_valid=0, PC=redirect target, state FETCH.
REQ-027 PC=64'hFFFF_FFFF_FFFF_FFFC, ack -> next imem_addr=0.
REQ-028 reset_n pulsed low mid-HOLD -> outputs at reset values immediately (asynchronous), fetch restarts at RESET_PC.
